// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if
//   Handshake bundle for the iterative divider.
//   Operand side : valid_i (in), ready_i (out), dividend, divisor
//   Result side  : valid_o (out), ready_o (in), quotient, remainder,
//                  div_by_zero
//   master modport : the producer/consumer around the divider
//   slave modport  : the divider itself
// -----------------------------------------------------------------------------
interface divider_if #(
  parameter int N = 8
);
  logic         valid_i;
  logic         ready_i;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;

  logic         valid_o;
  logic         ready_o;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output valid_i, dividend, divisor, ready_o,
    input  ready_i, valid_o, quotient, remainder, div_by_zero
  );

  modport slave (
    input  valid_i, dividend, divisor, ready_o,
    output ready_i, valid_o, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative unsigned restoring divider, one quotient bit per clock.
//   A divide by a non-zero divisor takes one accept edge plus N compute edges;
//   a zero divisor completes on the accept edge with quotient all ones,
//   remainder = dividend and div_by_zero set.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : divider_if.slave
//            valid_i/ready_i   operand handshake (ready_i high only in IDLE)
//            dividend/divisor  operands, latched on accept
//            valid_o/ready_o   result handshake (result held while stalled)
//            quotient/remainder/div_by_zero  result, qualified by valid_o
// -----------------------------------------------------------------------------
module divider #(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COMPUTING = 2'b01,
    DONE      = 2'b10
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [N-1:0]  q_reg;     // dividend shifting out the top, quotient in at the bottom
  logic [N-1:0]  div_reg;   // latched divisor
  logic [N:0]    prem;      // partial remainder, one extra bit so the compare never overflows
  logic [CW-1:0] cnt;

  logic [N-1:0]  res_quot;
  logic [N-1:0]  res_rem;
  logic          res_dbz;
  logic          res_valid;

  logic          accept;
  logic          last_step;
  logic [N:0]    trial;
  logic [N:0]    trial_sub;
  logic          trial_ge;
  logic [N:0]    prem_next;
  logic [N-1:0]  q_next;

  assign accept    = bus.valid_i && (state == IDLE);
  assign last_step = (cnt == CW'(N - 1));

  // One restoring step: bring the next dividend bit into the partial
  // remainder, subtract the divisor if it fits.
  assign trial     = {prem[N-1:0], q_reg[N-1]};
  assign trial_ge  = (trial >= {1'b0, div_reg});
  assign trial_sub = trial - {1'b0, div_reg};
  assign prem_next = trial_ge ? trial_sub : trial;
  assign q_next    = {q_reg[N-2:0], trial_ge};

  // The partial remainder is always below the divisor after a step, so its
  // top bit never feeds back; it only exists to keep the trial value exact.
  logic unused_prem_msb;
  assign unused_prem_msb = prem[N];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is
    // inferred; the unused encoding falls back to IDLE through it as well.
    state_next = IDLE;
    unique case (state)
      IDLE: begin
        if (accept) state_next = (bus.divisor == '0) ? DONE : COMPUTING;
        else        state_next = IDLE;
      end
      COMPUTING: state_next = last_step ? DONE : COMPUTING;
      DONE:      state_next = (res_valid && bus.ready_o) ? IDLE : DONE;
      default:   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg     <= '0;
      div_reg   <= '0;
      prem      <= '0;
      cnt       <= '0;
      res_quot  <= '0;
      res_rem   <= '0;
      res_dbz   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.divisor == '0) begin
              // Zero divisor: no iterations, report the conventional result.
              res_quot  <= '1;
              res_rem   <= bus.dividend;
              res_dbz   <= 1'b1;
              res_valid <= 1'b1;
            end else begin
              q_reg     <= bus.dividend;
              div_reg   <= bus.divisor;
              prem      <= '0;
              cnt       <= '0;
              res_dbz   <= 1'b0;
              res_valid <= 1'b0;
            end
          end
        end

        COMPUTING: begin
          q_reg <= q_next;
          prem  <= prem_next;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            res_quot  <= q_next;
            res_rem   <= prem_next[N-1:0];
            res_valid <= 1'b1;
          end
        end

        DONE: begin
          if (res_valid && bus.ready_o) res_valid <= 1'b0;
        end

        default: res_valid <= 1'b0;
      endcase
    end
  end

  assign bus.ready_i     = (state == IDLE);
  assign bus.valid_o     = res_valid;
  assign bus.quotient    = res_quot;
  assign bus.remainder   = res_rem;
  assign bus.div_by_zero = res_dbz;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Directed and randomised checks of divider at N=8 and N=16.
// -----------------------------------------------------------------------------
module tb_divider;

  logic clk;
  logic rst;

  int total;
  int bad;

  divider_if #(.N(8))  bus8  ();
  divider_if #(.N(16)) bus16 ();

  divider #(.N(8)) u_div8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  divider #(.N(16)) u_div16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One N=8 operation. Edges are counted from the accept edge (edge 1);
  // ro_delay cycles of ready_o=0 are applied once the result is up.
  task automatic do_div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                         input int ro_delay);
    int edges;
    edges = 0;
    while (!bus8.ready_i && edges < 50) begin tick(); edges++; end
    check({tag, ".rdy_in"}, 32'(bus8.ready_i), 32'd1);
    bus8.dividend = a;
    bus8.divisor  = b;
    bus8.valid_i  = 1'b1;
    tick();
    edges = 1;
    bus8.valid_i  = 1'b0;
    bus8.dividend = ~a;
    bus8.divisor  = ~b;
    while (!bus8.valid_o && edges < 50) begin tick(); edges++; end
    check({tag, ".lat"}, 32'(edges), (b == 8'd0) ? 32'd1 : 32'd9);
    check({tag, ".q"},   32'(bus8.quotient),    32'(eq));
    check({tag, ".r"},   32'(bus8.remainder),   32'(er));
    check({tag, ".dbz"}, 32'(bus8.div_by_zero), 32'(edbz));
    bus8.ready_o = (ro_delay == 0);
    for (int i = 0; i < ro_delay; i++) begin
      tick();
      check({tag, ".hold_v"}, 32'(bus8.valid_o),  32'd1);
      check({tag, ".hold_q"}, 32'(bus8.quotient), 32'(eq));
    end
    bus8.ready_o = 1'b1;
    tick();
    check({tag, ".v_clr"},  32'(bus8.valid_o), 32'd0);
    check({tag, ".rdy_up"}, 32'(bus8.ready_i), 32'd1);
  endtask

  task automatic do_div16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                          input int ro_delay);
    int edges;
    edges = 0;
    while (!bus16.ready_i && edges < 80) begin tick(); edges++; end
    check({tag, ".rdy_in"}, 32'(bus16.ready_i), 32'd1);
    bus16.dividend = a;
    bus16.divisor  = b;
    bus16.valid_i  = 1'b1;
    tick();
    edges = 1;
    bus16.valid_i  = 1'b0;
    bus16.dividend = ~a;
    bus16.divisor  = ~b;
    while (!bus16.valid_o && edges < 80) begin tick(); edges++; end
    check({tag, ".lat"}, 32'(edges), (b == 16'd0) ? 32'd1 : 32'd17);
    check({tag, ".q"},   32'(bus16.quotient),    32'(eq));
    check({tag, ".r"},   32'(bus16.remainder),   32'(er));
    check({tag, ".dbz"}, 32'(bus16.div_by_zero), 32'(edbz));
    bus16.ready_o = (ro_delay == 0);
    for (int i = 0; i < ro_delay; i++) begin
      tick();
      check({tag, ".hold_v"}, 32'(bus16.valid_o), 32'd1);
    end
    bus16.ready_o = 1'b1;
    tick();
    check({tag, ".v_clr"},  32'(bus16.valid_o), 32'd0);
    check({tag, ".rdy_up"}, 32'(bus16.ready_i), 32'd1);
  endtask

  initial begin
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus8.valid_i   = 1'b0;
    bus8.ready_o   = 1'b1;
    bus8.dividend  = '0;
    bus8.divisor   = '0;
    bus16.valid_i  = 1'b0;
    bus16.ready_o  = 1'b1;
    bus16.dividend = '0;
    bus16.divisor  = '0;

    // Reset state
    #12;
    check("rst.ready_i", 32'(bus8.ready_i),     32'd1);
    check("rst.valid_o", 32'(bus8.valid_o),     32'd0);
    check("rst.q",       32'(bus8.quotient),    32'd0);
    check("rst.r",       32'(bus8.remainder),   32'd0);
    check("rst.dbz",     32'(bus8.div_by_zero), 32'd0);
    check("rst.v16",     32'(bus16.valid_o),    32'd0);
    rst = 1'b1;
    tick();

    // Directed N=8 vectors
    do_div8("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 0);
    do_div8("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0);
    do_div8("d5_200",   8'd5,   8'd200, 8'd0,   8'd5,   1'b0, 0);
    do_div8("d42_0",    8'd42,  8'd0,   8'hFF,  8'd42,  1'b1, 0);
    do_div8("d100_7b",  8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 0);
    do_div8("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 0);
    do_div8("d255_255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0);
    do_div8("d254_255", 8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 0);
    do_div8("d128_2",   8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 0);
    do_div8("d1_0",     8'd1,   8'd0,   8'hFF,  8'd1,   1'b1, 2);

    // Backpressure: result held, new operands ignored while not in IDLE
    bus8.ready_o  = 1'b0;
    bus8.dividend = 8'd100;
    bus8.divisor  = 8'd7;
    bus8.valid_i  = 1'b1;
    tick();
    bus8.valid_i  = 1'b0;
    for (int i = 0; i < 20 && !bus8.valid_o; i++) tick();
    check("bp.valid", 32'(bus8.valid_o), 32'd1);
    bus8.dividend = 8'd50;
    bus8.divisor  = 8'd3;
    bus8.valid_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.v",   32'(bus8.valid_o),     32'd1);
      check("bp.q",   32'(bus8.quotient),    32'd14);
      check("bp.r",   32'(bus8.remainder),   32'd2);
      check("bp.rdy", 32'(bus8.ready_i),     32'd0);
    end
    bus8.valid_i = 1'b0;
    bus8.ready_o = 1'b1;
    tick();
    check("bp.v_clr",  32'(bus8.valid_o),  32'd0);
    check("bp.rdy_up", 32'(bus8.ready_i),  32'd1);
    check("bp.q_keep", 32'(bus8.quotient), 32'd14);
    do_div8("bp_next", 8'd60, 8'd4, 8'd15, 8'd0, 1'b0, 0);

    // Asynchronous reset in the middle of a computation
    bus8.dividend = 8'd200;
    bus8.divisor  = 8'd9;
    bus8.valid_i  = 1'b1;
    tick();
    bus8.valid_i  = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst.valid_o", 32'(bus8.valid_o),     32'd0);
    check("arst.q",       32'(bus8.quotient),    32'd0);
    check("arst.r",       32'(bus8.remainder),   32'd0);
    check("arst.dbz",     32'(bus8.div_by_zero), 32'd0);
    check("arst.ready_i", 32'(bus8.ready_i),     32'd1);
    #2 rst = 1'b1;
    tick();
    do_div8("arst_200_9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 0);

    // Directed N=16 vectors
    do_div16("w60000_7", 16'd60000, 16'd7,   16'd8571, 16'd3,     1'b0, 0);
    do_div16("w65535_0", 16'd65535, 16'd0,   16'hFFFF, 16'd65535, 1'b1, 0);
    do_div16("w1000_33", 16'd1000,  16'd33,  16'd30,   16'd10,    1'b0, 1);

    // Random sweeps with idle gaps and result backpressure
    for (int n = 0; n < 400; n++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) b8 = 8'($urandom_range(0, 7));
      bus8.ready_o = 1'($urandom_range(0, 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      if (b8 == 8'd0) do_div8("r8", a8, b8, 8'hFF,   a8,      1'b1, $urandom_range(0, 3));
      else            do_div8("r8", a8, b8, a8 / b8, a8 % b8, 1'b0, $urandom_range(0, 3));
    end

    for (int n = 0; n < 200; n++) begin
      a16 = 16'($urandom_range(0, 65535));
      b16 = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 3) == 0) b16 = 16'($urandom_range(1, 300));
      bus16.ready_o = 1'($urandom_range(0, 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      if (b16 == 16'd0) do_div16("r16", a16, b16, 16'hFFFF,   a16,       1'b1, $urandom_range(0, 3));
      else              do_div16("r16", a16, b16, a16 / b16, a16 % b16, 1'b0, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
